fc_vector_loader: RTL and testbench
===================================

// Module: fc_vector_loader
// PURPOSE
// - Writer side of the fully-connected layer input vector x[0:IN-1].
// - Accepts a valid/ready stream of WIDTH-bit activations, one per beat, and assembles IN of them into a register bank.
// - Presents the bank as a stable parallel vector with x_valid until the layer consumer acknowledges with x_ready.
// - Sits between the previous layer's serial output and the combinational booth/adder-tree/ReLU layer.
// PARAMETERS
// - WIDTH  8    activation width in bits; matches the layer's WIDTH
// - IN     128  vector length; the index counter is $clog2(IN) bits wide
// PORTS
// - clk       in   1      single clock; all logic is on the rising edge
// - rst       in   1      synchronous reset, active-high
// - s_valid   in   1      input beat valid
// - s_ready   out  1      loader can accept a beat
// - s_data    in   WIDTH  activation value
// - s_last    in   1      marks the final beat of a frame
// - x         out  WIDTH  x[0:IN-1], unpacked array driving the layer input
// - x_valid   out  1      x is complete and stable
// - x_ready   in   1      consumer has sampled the layer output; release x
// - err_len   out  1      one-cycle pulse on a frame-length mismatch
// BEHAVIOUR
// - Reset: idx=0, all bank entries 0, x_valid=0, err_len=0, state=FILL.
//   - s_ready=0 during the rst cycle and 1 from the first cycle after it.
// - A beat is accepted when s_valid && s_ready.
//   - Accept writes bank[idx]=s_data and increments idx.
// - FILL state: s_ready=1 and x_valid=0.
//   - Accept with idx==IN-1: go to HOLD and set idx=0.
//     - s_last=0 on this beat: pulse err_len for one cycle; the frame is still completed.
//   - Accept with s_last=1 and idx<IN-1 (short frame): pulse err_len and go to HOLD.
//     - Entries above idx keep the 0 they were cleared to.
// - HOLD state: x_valid=1, s_ready=0, and x is held constant bit-for-bit.
//   - x_ready=1: go to FILL, clear every bank entry to 0, set idx=0.
//   - s_ready returns to 1 on the next cycle.
//   - x_ready while x_valid=0 is ignored.
// - Latency:
//   - The final accepted beat in cycle N gives x_valid=1 in cycle N+1.
//   - x_ready in cycle M gives x_valid=0 and s_ready=1 in cycle M+1.
// - Peak throughput: one frame per IN+1 cycles.
// - No arithmetic on the data; values pass through unmodified (signed, WIDTH bits).
// - rst asserted mid-frame or during HOLD discards the partial or held frame.
//   - It also clears err_len in the same cycle.
// - s_data and s_last are don't-care when s_valid=0.
// CONFIGURATION
// - FC_LOADER_PINGPONG_EN defined:
//   - Two banks, active and shadow. x is driven from the active bank.
//   - FILL writes the shadow bank. s_ready stays 1 while the shadow bank is not complete, including during HOLD.
//   - When the shadow bank is complete and the active bank is not held (x_valid=0), or x_ready arrives in the same cycle, the banks swap.
//     - x_valid=1 on the next cycle.
//     - The new shadow bank is cleared, then s_ready=1.
//   - When the shadow bank is complete while the active bank is held: s_ready=0 until x_ready, then swap.
//   - Peak throughput: one frame per IN cycles.
// - FC_LOADER_PINGPONG_EN not defined: single bank, behaviour exactly as in BEHAVIOUR.
// TESTING
// - Full frame: send s_data=i+1 for i=0..127, s_last on i=127, x_ready=0.
//   -> x_valid=1 one cycle after the last beat; x[0]=1, x[127]=128; s_ready=0; err_len never pulses.
// - Hold/release: hold x_ready=0 for 20 cycles, then 1 for one cycle.
//   -> x is unchanged for all 20 cycles; next cycle x_valid=0, s_ready=1, every x[i]=0.
// - Short frame: s_last on beat 9 with data 0x55.
//   -> err_len is a single pulse; x_valid=1; x[0..9]=0x55; x[10..127]=0.
// - Long frame: 128 beats with s_last never asserted.
//   -> err_len pulses in the cycle after beat 127; x_valid=1; the next beats stall (s_ready=0).
// - Reset at beat 64 with rst for 1 cycle, then a full frame of 0xA0.
//   -> all 128 entries are 0xA0; x_valid asserts only after the new 128th beat.
// - Pingpong (macro defined): stream 256 beats back-to-back, x_ready asserted for 1 cycle after each x_valid rise.
//   -> s_ready never drops after the reset cycle; frame 2 is presented the cycle after its last beat.

Source files
------------

// File: rtl/fc_vector_loader.sv
// fc_vector_loader: serial-to-parallel loader for the fully-connected layer input.
// Collects IN signed activations from a valid/ready stream into a register bank
// and presents them as x[0:IN-1] with x_valid until the consumer returns x_ready.
// Build option FC_LOADER_PINGPONG_EN: double-buffered banks, so the next frame
// streams into a shadow bank while the active bank is held for the layer.
module fc_vector_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic signed [WIDTH-1:0] x [IN],
    output logic                    x_valid,
    input  logic                    x_ready,
    output logic                    err_len
);
    localparam int            IW       = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic          accept;
    logic          last_idx;
    logic          done;

    assign accept   = s_valid && s_ready;
    assign last_idx = (idx == LAST_IDX);
    // A frame ends either on the IN-th beat or on an early s_last.
    assign done     = accept && (last_idx || s_last);

    // Beat index and frame-length error pulse (s_last disagreeing with the final index).
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= done && (last_idx != s_last);
            if (accept) begin
                idx <= done ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef FC_LOADER_PINGPONG_EN
    // state tracks the shadow bank: FILL while collecting, HOLD once complete
    // but blocked because the active bank is still held by the consumer.
    logic signed [WIDTH-1:0] bank [2][IN];
    logic                    sel;
    logic                    held;
    logic                    swap;

    assign s_ready = !rst && (state == FILL);
    assign x_valid = held;
    // Swap as soon as a complete shadow frame exists and the active bank is free.
    assign swap    = (done || (state == HOLD)) && (!held || x_ready);

    // Next-state decode for the shadow bank.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (done && !swap) state_next = HOLD;
            HOLD:    if (swap) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // State register plus active-bank select and hold flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            sel   <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_next;
            if (swap) begin
                sel  <= ~sel;
                held <= 1'b1;
            end else if (x_ready) begin
                held <= 1'b0;
            end
        end
    end

    // Banks: the outgoing active bank is cleared on swap; beats land in the shadow.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < IN; i++) begin
                if (rst || (swap && (sel == b[0]))) begin
                    bank[b][i] <= '0;
                end else if (accept && (sel != b[0]) && (idx == IW'(i))) begin
                    bank[b][i] <= s_data;
                end
            end
        end
    end

    // Parallel vector comes from the active bank.
    always_comb begin
        for (int i = 0; i < IN; i++) begin
            x[i] = bank[sel][i];
        end
    end
`else
    logic signed [WIDTH-1:0] bank [IN];

    assign s_ready = !rst && (state == FILL);
    assign x_valid = (state == HOLD);

    // Next-state decode: fill until the frame ends, hold until acknowledged.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (done) state_next = HOLD;
            HOLD:    if (x_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Bank: write accepted beats; clear on reset and on release so short frames zero-pad.
    always_ff @(posedge clk) begin
        if (rst || ((state == HOLD) && x_ready)) begin
            for (int i = 0; i < IN; i++) begin
                bank[i] <= '0;
            end
        end else if (accept) begin
            bank[idx] <= s_data;
        end
    end

    // Parallel vector straight from the bank.
    always_comb begin
        for (int i = 0; i < IN; i++) begin
            x[i] = bank[i];
        end
    end
`endif

endmodule

// File: tb/tb_fc_vector_loader.sv
// Self-checking bench for fc_vector_loader (WIDTH=8, IN=128).
module tb_fc_vector_loader;
    localparam int WIDTH = 8;
    localparam int IN    = 128;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_data;
    logic                    s_last;
    logic signed [WIDTH-1:0] x [IN];
    logic                    x_valid;
    logic                    x_ready;
    logic                    err_len;

    int total   = 0;
    int bad     = 0;
    int err_cnt = 0;
    logic signed [WIDTH-1:0] exp_q[$];

    fc_vector_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .x(x), .x_valid(x_valid),
        .x_ready(x_ready), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Counts cycles in which err_len is high.
    always @(negedge clk) if (err_len === 1'b1) err_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic signed [WIDTH-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset;
        int nz;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; x_ready = 1'b0;
        tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
        total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL reset_x_valid got=%b want=0", x_valid); end
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL reset_err_len got=%b want=0", err_len); end
        nz = 0;
        for (int i = 0; i < IN; i++) if (x[i] !== '0) nz++;
        total++; if (nz !== 0) begin bad++; $display("FAIL reset_bank nonzero=%0d want=0", nz); end
        rst = 1'b0;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_s_ready got=%b want=1", s_ready); end
    endtask

    task automatic test_full_frame;
        int e0;
        logic signed [WIDTH-1:0] e;
        e0 = err_cnt;
        for (int i = 0; i < IN; i++) begin
            exp_q.push_back(WIDTH'(i + 1));
            drive_beat(WIDTH'(i + 1), i == IN - 1);
        end
        total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL full_x_valid got=%b want=1", x_valid); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_s_ready got=%b want=0", s_ready); end
        for (int i = 0; i < IN; i++) begin
            e = exp_q.pop_front();
            total++; if (x[i] !== e) begin bad++; $display("FAIL full_x[%0d] got=%h want=%h", i, x[i], e); end
        end
        tick();
        total++; if (err_cnt !== e0) begin bad++; $display("FAIL full_err_pulses got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_hold_release;
        logic signed [WIDTH-1:0] snap [IN];
        int diff, nz;
        for (int i = 0; i < IN; i++) snap[i] = x[i];
        x_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            diff = 0;
            for (int i = 0; i < IN; i++) if (x[i] !== snap[i]) diff++;
            total++; if (diff !== 0 || x_valid !== 1'b1) begin
                bad++; $display("FAIL hold_stable cycle=%0d changed=%0d x_valid=%b want 0/1", c, diff, x_valid);
            end
        end
        x_ready = 1'b1;
        tick();
        x_ready = 1'b0;
        total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL release_x_valid got=%b want=0", x_valid); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready got=%b want=1", s_ready); end
        nz = 0;
        for (int i = 0; i < IN; i++) if (x[i] !== '0) nz++;
        total++; if (nz !== 0) begin bad++; $display("FAIL release_clear nonzero=%0d want=0", nz); end
    endtask

    task automatic test_short_frame;
        int e0;
        logic signed [WIDTH-1:0] e;
        e0 = err_cnt;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'h55);
            drive_beat(8'h55, i == 9);
        end
        for (int i = 10; i < IN; i++) exp_q.push_back('0);
        total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL short_x_valid got=%b want=1", x_valid); end
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL short_err_len got=%b want=1", err_len); end
        for (int i = 0; i < IN; i++) begin
            e = exp_q.pop_front();
            total++; if (x[i] !== e) begin bad++; $display("FAIL short_x[%0d] got=%h want=%h", i, x[i], e); end
        end
        tick();
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL short_err_width got=%b want=0", err_len); end
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL short_err_pulses got=%0d want=1", err_cnt - e0); end
        x_ready = 1'b1; tick(); x_ready = 1'b0;
    endtask

    task automatic test_long_frame;
        logic signed [WIDTH-1:0] e;
        for (int i = 0; i < IN; i++) begin
            exp_q.push_back(WIDTH'(i * 7 + 200));
            drive_beat(WIDTH'(i * 7 + 200), 1'b0);
        end
        total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL long_x_valid got=%b want=1", x_valid); end
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL long_err_len got=%b want=1", err_len); end
        s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL long_stall cycle=%0d s_ready=%b want=0", c, s_ready); end
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < IN; i++) begin
            e = exp_q.pop_front();
            total++; if (x[i] !== e) begin bad++; $display("FAIL long_x[%0d] got=%h want=%h", i, x[i], e); end
        end
        x_ready = 1'b1; tick(); x_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic signed [WIDTH-1:0] e;
        for (int i = 0; i < 64; i++) drive_beat(8'h11, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < IN; i++) begin
            if (i == IN - 1) begin
                total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early_valid got=%b want=0", x_valid); end
            end
            exp_q.push_back(8'hA0);
            drive_beat(8'hA0, i == IN - 1);
        end
        total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL rstmid_x_valid got=%b want=1", x_valid); end
        for (int i = 0; i < IN; i++) begin
            e = exp_q.pop_front();
            total++; if (x[i] !== e) begin bad++; $display("FAIL rstmid_x[%0d] got=%h want=%h", i, x[i], e); end
        end
        x_ready = 1'b1; tick(); x_ready = 1'b0;
    endtask

`ifdef FC_LOADER_PINGPONG_EN
    task automatic test_pingpong;
        logic xv_prev;
        int frames;
        logic signed [WIDTH-1:0] e;
        xv_prev = x_valid;
        frames  = 0;
        for (int i = 0; i < 2 * IN; i++) begin
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL pp_s_ready beat=%0d got=%b want=1", i, s_ready); end
            exp_q.push_back(WIDTH'(i));
            s_valid = 1'b1; s_data = WIDTH'(i); s_last = ((i % IN) == IN - 1);
            tick();
            x_ready = 1'b0;
            if (x_valid === 1'b1 && xv_prev !== 1'b1) begin
                frames++;
                for (int k = 0; k < IN; k++) begin
                    e = exp_q.pop_front();
                    total++; if (x[k] !== e) begin bad++; $display("FAIL pp_x[%0d] frame=%0d got=%h want=%h", k, frames, x[k], e); end
                end
                x_ready = 1'b1;
            end
            xv_prev = x_valid;
        end
        s_valid = 1'b0; s_last = 1'b0;
        total++; if (frames !== 2) begin bad++; $display("FAIL pp_frames got=%0d want=2", frames); end
        tick();
        x_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef FC_LOADER_PINGPONG_EN
        test_pingpong();
`else
        test_full_frame();
        test_hold_release();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
